// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: byte-addressed RV32 load/store to word memory sequencer; define LSU_MISALIGN_TRAP_EN to trap word-crossing accesses
module lsu_mem_sequencer #(
  parameter int XLEN = 32,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAPT, RESP} state_t;
  state_t      state;
  logic        store_q, split_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  hi_strb_q;
  logic [31:0] hi_wdata_q, lo_q;
  logic [1:0]  size, off;
  logic [3:0]  mask;
  logic [7:0]  strb8;
  logic [63:0] data64, v64;
  logic [31:0] lo_w, hi_w, v, ext;
  logic        split, legal, reject;
  logic        unused;

  assign req_ready = state == IDLE;
  assign size = req_funct3[1:0];
  assign off = req_addr[1:0];
  assign unused = ^{req_addr[XLEN-1:MEM_AW+2], v64[63:32]};

  // Request decode: lane placement, word-crossing detection and funct3 legality
  always_comb begin
    mask = size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : 4'b1111;
    strb8 = {4'b0000, mask} << off;
    data64 = {32'b0, req_wdata} << {off, 3'b000};
    split = (size == 2'd1 && off == 2'd3) || (size == 2'd2 && off != 2'd0);
    legal = req_store ? (!req_funct3[2] && size != 2'd3) : (size != 2'd3 && !(req_funct3[2] && size == 2'd2));
`ifdef LSU_MISALIGN_TRAP_EN
    reject = !legal || split;
`else
    reject = !legal;
`endif
  end

  // Load assembly: shift the {hi,lo} pair down by the byte offset, then extend
  always_comb begin
    lo_w = split_q ? lo_q : mem_rdata;
    hi_w = split_q ? mem_rdata : 32'b0;
    v64 = {hi_w, lo_w} >> {off_q, 3'b000};
    v = v64[31:0];
    ext = funct3_q[1] ? v :
          funct3_q[0] ? {{16{v[15] & ~funct3_q[2]}}, v[15:0]} :
                        {{24{v[7] & ~funct3_q[2]}}, v[7:0]};
  end

  // Sequencer FSM with registered memory and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      store_q <= 1'b0;
      split_q <= 1'b0;
      funct3_q <= 3'b0;
      off_q <= 2'b0;
      hi_strb_q <= 4'b0;
      hi_wdata_q <= 32'b0;
      lo_q <= 32'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wstrb <= 4'b0;
      mem_wdata <= 32'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          store_q <= req_store;
          split_q <= split;
          funct3_q <= req_funct3;
          off_q <= off;
          hi_strb_q <= req_store ? strb8[7:4] : 4'b0;
          hi_wdata_q <= data64[63:32];
          if (reject) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state <= ACC0;
            mem_en <= 1'b1;
            mem_we <= req_store;
            mem_addr <= req_addr[MEM_AW+1:2];
            mem_wstrb <= req_store ? strb8[3:0] : 4'b0;
            mem_wdata <= data64[31:0];
          end
        end
        ACC0: begin
          state <= split_q ? ACC1 : CAPT;
          mem_en <= split_q;
          mem_we <= split_q && store_q;
          mem_addr <= split_q ? mem_addr + 1'b1 : mem_addr;
          mem_wstrb <= split_q ? hi_strb_q : 4'b0;
          mem_wdata <= hi_wdata_q;
        end
        ACC1: begin
          state <= CAPT;
          lo_q <= mem_rdata;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          mem_wstrb <= 4'b0;
        end
        CAPT: begin
          state <= RESP;
          rsp_valid <= 1'b1;
          rsp_err <= 1'b0;
          rsp_rdata <= store_q ? '0 : ext;
        end
        default: begin
          state <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb_lsu_mem_sequencer: byte-level reference model checked against the sequencer every cycle
module tb_lsu_mem_sequencer;
  localparam bit TRAP =
`ifdef LSU_MISALIGN_TRAP_EN
    1'b1;
`else
    1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        rsp_valid, rsp_err, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] phys [256];
  logic [7:0]  mb [1024];
  int          cyc = 0, n_cmp = 0, n_err = 0;
  bit          chk_on = 1'b0;
  int          acc0_c = -1, acc1_c = -1, rsp_c = -1, t_acc = 0, rsp_seen = 0;
  logic [7:0]  a0, a1, rec_a0, rec_a1;
  logic [3:0]  s0, s1, rec_s0, rec_s1;
  logic [31:0] d0, d1, rec_d0, rec_d1, e_rdata, last_rdata;
  logic        e_err, e_store, last_err, e_en, hi;

  lsu_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we && mem_wstrb[i]) phys[mem_addr][8*i+:8] <= mem_wdata[8*i+:8];
      mem_rdata <= phys[mem_addr];
    end
  end

  function automatic logic [31:0] lm(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'd0: return {{24{raw[7]}}, raw[7:0]};
      3'd1: return {{16{raw[15]}}, raw[15:0]};
      3'd4: return {24'b0, raw[7:0]};
      3'd5: return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      e_en = (cyc == acc0_c) || (cyc == acc1_c);
      check("mem_en", {31'b0, mem_en}, {31'b0, e_en});
      if (e_en && mem_en) begin
        hi = cyc == acc1_c;
        check("mem_addr", {24'b0, mem_addr}, {24'b0, hi ? a1 : a0});
        check("mem_we", {31'b0, mem_we}, {31'b0, e_store});
        if (e_store) begin
          check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, hi ? s1 : s0});
          check("mem_wdata", mem_wdata & lm(hi ? s1 : s0), (hi ? d1 : d0) & lm(hi ? s1 : s0));
        end
        if (hi) begin rec_a1 = mem_addr; rec_s1 = mem_wstrb; rec_d1 = mem_wdata; end
        else begin rec_a0 = mem_addr; rec_s0 = mem_wstrb; rec_d0 = mem_wdata; end
      end
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, cyc == rsp_c});
      if (cyc == rsp_c && rsp_valid) begin
        check("rsp_rdata", rsp_rdata, e_rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
        last_rdata = rsp_rdata;
        last_err = rsp_err;
        rsp_seen = cyc;
      end
    end
  end

  task automatic plan(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n, off, lane;
    logic [9:0] b;
    logic [31:0] raw;
    logic legal, split;
    n = 1 << f3[1:0];
    off = int'(addr[1:0]);
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    split = off + n > 4;
    e_store = st;
    e_err = !legal || (TRAP && split);
    t_acc = cyc;
    rec_a0 = 0; rec_a1 = 0; rec_s0 = 0; rec_s1 = 0; rec_d0 = 0; rec_d1 = 0;
    last_rdata = 32'hFFFF_FFFF; last_err = 1'b0; rsp_seen = -100;
    s0 = 0; s1 = 0; d0 = 0; d1 = 0; raw = 0;
    if (e_err) begin
      acc0_c = -1; acc1_c = -1; rsp_c = cyc + 1; e_rdata = 0;
    end else begin
      acc0_c = cyc + 1;
      acc1_c = split ? cyc + 2 : -1;
      rsp_c = cyc + (split ? 4 : 3);
      a0 = addr[9:2];
      a1 = a0 + 8'd1;
      for (int i = 0; i < n; i++) begin
        b = addr[9:0] + 10'(i);
        lane = off + i;
        if (st) begin
          if (lane < 4) begin s0[lane] = 1'b1; d0[8*lane+:8] = wd[8*i+:8]; end
          else begin s1[lane-4] = 1'b1; d1[8*(lane-4)+:8] = wd[8*i+:8]; end
          mb[b] = wd[8*i+:8];
        end else raw[8*i+:8] = mb[b];
      end
      e_rdata = st ? 32'b0 : extend(f3, raw);
    end
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
      return;
    end
    req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    plan(st, f3, addr, wd);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    issue(st, f3, addr, wd);
    while (cyc <= rsp_c + 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    run(1, 3'd2, 32'h010, 32'hDEADBEEF);
    run(1, 3'd2, 32'h3FC, 32'h11223344);
    run(1, 3'd2, 32'h000, 32'hAABBCCDD);

    run(0, 3'd2, 32'h010, 0);
    check("lw_lit", last_rdata, 32'hDEADBEEF);
    check("lw_addr_lit", {24'b0, rec_a0}, 32'd4);
    check("lw_lat_lit", rsp_seen - t_acc, 32'd3);
    run(0, 3'd0, 32'h013, 0);
    check("lb_lit", last_rdata, 32'hFFFFFFDE);
    run(0, 3'd4, 32'h013, 0);
    check("lbu_lit", last_rdata, 32'h000000DE);
    run(0, 3'd5, 32'h012, 0);
    check("lhu_lit", last_rdata, 32'h0000DEAD);

    run(1, 3'd1, 32'h007, 32'h00001234);
    check("sh_a0_lit", {24'b0, rec_a0}, TRAP ? 32'd0 : 32'd1);
    check("sh_s0_lit", {28'b0, rec_s0}, TRAP ? 32'd0 : 32'b1000);
    check("sh_d0_lit", {24'b0, rec_d0[31:24]}, TRAP ? 32'd0 : 32'h34);
    check("sh_a1_lit", {24'b0, rec_a1}, TRAP ? 32'd0 : 32'd2);
    check("sh_s1_lit", {28'b0, rec_s1}, TRAP ? 32'd0 : 32'b0001);
    check("sh_d1_lit", {24'b0, rec_d1[7:0]}, TRAP ? 32'd0 : 32'h12);
    check("sh_lat_lit", rsp_seen - t_acc, TRAP ? 32'd1 : 32'd4);
    check("sh_err_lit", {31'b0, last_err}, {31'b0, TRAP});
    run(0, 3'd1, 32'h007, 0);
    check("lh_split_lit", last_rdata, TRAP ? 32'd0 : 32'h00001234);

    run(0, 3'd2, 32'h3FE, 0);
    check("lw_wrap_lit", last_rdata, TRAP ? 32'd0 : 32'hCCDD1122);
    check("lw_wrap_a0_lit", {24'b0, rec_a0}, TRAP ? 32'd0 : 32'd255);
    check("lw_wrap_a1_lit", {24'b0, rec_a1}, 32'd0);
    run(0, 3'd5, 32'h3FF, 0);
    check("lhu_wrap_lit", last_rdata, TRAP ? 32'd0 : 32'h0000DD11);
    run(0, 3'd4, 32'h3FE, 0);
    check("lbu_3fe_lit", last_rdata, 32'h00000022);

    run(0, 3'd3, 32'h010, 0);
    check("ill_ld_err_lit", {31'b0, last_err}, 32'd1);
    check("ill_ld_rdata_lit", last_rdata, 32'd0);
    check("ill_ld_lat_lit", rsp_seen - t_acc, 32'd1);
    run(1, 3'd4, 32'h010, 32'h55555555);
    check("ill_st_err_lit", {31'b0, last_err}, 32'd1);
    check("ill_st_lat_lit", rsp_seen - t_acc, 32'd1);

    run(1, 3'd2, 32'h020, 32'h01020304);
    run(1, 3'd0, 32'h021, 32'hFFFFFF5A);
    run(0, 3'd2, 32'h020, 0);
    check("sb_merge_lit", last_rdata, 32'h01025A04);
    run(1, 3'd2, 32'h030, 32'h89ABCDEF);
    run(0, 3'd1, 32'h032, 0);
    check("lh_hi_lit", last_rdata, 32'hFFFF89AB);
    run(0, 3'd4, 32'h031, 0);
    check("lbu_lane1_lit", last_rdata, 32'h000000CD);

    issue(1, 3'd1, 32'h007, 32'h0000ABCD);
    while (cyc < t_acc + 2) @(negedge clk);
    rst_n = 1'b0;
    if (rsp_c > cyc) rsp_c = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", {31'b0, req_ready}, 32'd1);
    run(0, 3'd2, 32'h010, 0);
    check("lw_after_rst_lit", last_rdata, 32'hDEADBEEF);
    run(0, 3'd1, 32'h007, 0);
    check("lh_after_rst_lit", last_rdata, TRAP ? 32'd0 : 32'hFFFFABCD);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
